// File: rtl/cf_seq_math_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cf_seq_math_pkg
// Description : Shared types and helpers for the run-time ceil-div / clog2
//               sequencer: operation and state encodings plus the width of
//               the step/bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
package cf_seq_math_pkg;

    typedef enum logic {
        OP_CEIL_DIV = 1'b0,
        OP_LOG2     = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // The counter must reach WIDTH (largest clog2 result), hence WIDTH+1 values.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cf_div_step.sv
`default_nettype none
// ============================================================================
// Module      : cf_div_step
// Description : One combinational restoring-division step. Shifts the next
//               dividend bit into the partial remainder and subtracts the
//               divisor when it fits.
// Ports       : rem_in        partial remainder (always < divisor)
//               dividend_bit  next dividend bit, MSB first
//               divisor       divisor (non-zero)
//               rem_out       new partial remainder (< divisor)
//               quo_bit       quotient bit produced by this step
// Revision    : 1.0 - initial release
// ============================================================================
module cf_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             quo_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // shifted < 2*divisor, so when the subtraction does not borrow the
    // difference fits in WIDTH bits; when it borrows the MSB is set.
    assign shifted = {rem_in, dividend_bit};
    assign trial   = shifted - {1'b0, divisor};
    assign quo_bit = ~trial[WIDTH];
    assign rem_out = quo_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/cf_seq_math_unit.sv
`default_nettype none
// ============================================================================
// Module      : cf_seq_math_unit
// Description : Multi-cycle sequencer computing ceil(a/b) (restoring
//               division, one quotient bit per cycle) and clog2(a) (shift
//               and count) on a shared datapath, with valid/ready request
//               and response handshakes.
// Config      : CF_SEQ_MATH_LOG2_EN - when defined the LOG2 datapath is
//               built; otherwise LOG2 requests complete immediately with
//               result 0 and err=1.
// Ports       : clk_i, rst_ni (sync, active-low)
//               req_valid_i/req_ready_o, req_op_i, req_a_i, req_b_i
//               rsp_valid_o/rsp_ready_i, rsp_result_o, rsp_err_o
//               busy_o - high whenever the unit is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module cf_seq_math_unit
    import cf_seq_math_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_op_i,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_result_o,
    output logic             rsp_err_o,
    output logic             busy_o
);

    localparam int            CW        = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_e           state, state_d;
    logic [WIDTH-1:0] rem, rem_d;      // partial remainder
    logic [WIDTH-1:0] quo, quo_d;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs, dvs_d;      // latched divisor
    logic [CW-1:0]    cnt, cnt_d;      // division step / log2 bit counter
    logic [WIDTH-1:0] result, result_d;
    logic             err, err_d;
`ifdef CF_SEQ_MATH_LOG2_EN
    op_e              op, op_d;
    logic [WIDTH-1:0] tmp, tmp_d;      // remaining bits of (a-1)
    logic [WIDTH-1:0] tmp_shr;
    logic [WIDTH-1:0] log_arg;
`endif

    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    cf_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_in      (rem),
        .dividend_bit(quo[WIDTH-1]),
        .divisor     (dvs),
        .rem_out     (step_rem),
        .quo_bit     (step_q)
    );

`ifdef CF_SEQ_MATH_LOG2_EN
    assign tmp_shr = tmp >> 1;
    // clog2(0) is defined as clog2(1) = 0, so a=0 loads zero instead of wrapping.
    assign log_arg = (req_a_i == '0) ? '0 : req_a_i - WIDTH'(1);
`endif

    always_comb begin
        state_d  = state;
        rem_d    = rem;
        quo_d    = quo;
        dvs_d    = dvs;
        cnt_d    = cnt;
        result_d = result;
        err_d    = err;
`ifdef CF_SEQ_MATH_LOG2_EN
        op_d     = op;
        tmp_d    = tmp;
`endif
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    cnt_d = '0;
`ifdef CF_SEQ_MATH_LOG2_EN
                    op_d  = op_e'(req_op_i);
`endif
                    if (req_op_i == OP_CEIL_DIV) begin
                        if (req_b_i == '0) begin
                            result_d = '1;
                            err_d    = 1'b1;
                            state_d  = DONE;
                        end else begin
                            rem_d   = '0;
                            quo_d   = req_a_i;
                            dvs_d   = req_b_i;
                            state_d = BUSY;
                        end
                    end else begin
`ifdef CF_SEQ_MATH_LOG2_EN
                        tmp_d = log_arg;
                        if (log_arg == '0) begin
                            result_d = '0;
                            err_d    = 1'b0;
                            state_d  = DONE;
                        end else begin
                            state_d = BUSY;
                        end
`else
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = DONE;
`endif
                    end
                end
            end
            BUSY: begin
`ifdef CF_SEQ_MATH_LOG2_EN
                if (op == OP_LOG2) begin
                    tmp_d = tmp_shr;
                    cnt_d = cnt + CW'(1);
                    if (tmp_shr == '0) begin
                        result_d = WIDTH'(cnt_d);
                        err_d    = 1'b0;
                        state_d  = DONE;
                    end
                end else begin
`endif
                    rem_d = step_rem;
                    quo_d = {quo[WIDTH-2:0], step_q};
                    cnt_d = cnt + CW'(1);
                    if (cnt == LAST_STEP) begin
                        state_d = FIN;
                    end
`ifdef CF_SEQ_MATH_LOG2_EN
                end
`endif
            end
            FIN: begin
                // Round up whenever the division left a remainder.
                result_d = quo + {{(WIDTH-1){1'b0}}, |rem};
                err_d    = 1'b0;
                state_d  = DONE;
            end
            DONE: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state  <= IDLE;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            result <= '0;
            err    <= 1'b0;
`ifdef CF_SEQ_MATH_LOG2_EN
            op     <= OP_CEIL_DIV;
            tmp    <= '0;
`endif
        end else begin
            state  <= state_d;
            rem    <= rem_d;
            quo    <= quo_d;
            dvs    <= dvs_d;
            cnt    <= cnt_d;
            result <= result_d;
            err    <= err_d;
`ifdef CF_SEQ_MATH_LOG2_EN
            op     <= op_d;
            tmp    <= tmp_d;
`endif
        end
    end

    assign req_ready_o  = (state == IDLE);
    assign rsp_valid_o  = (state == DONE);
    assign busy_o       = (state != IDLE);
    assign rsp_result_o = result;
    assign rsp_err_o    = err;

endmodule
`default_nettype wire
